pixel_stream_ctrl: RTL
======================

# pixel_stream_ctrl

Raster-scan read sequencer for the blur output path. On a start pulse it walks a WIDTH x HEIGHT pixel buffer held in a synchronous-read RAM and emits every pixel in raster order on a valid/ready stream. The stream carries end-of-line and end-of-frame markers, so the downstream file-write stage can insert row separators and close out a frame. The block absorbs the RAM's one-cycle read latency and downstream backpressure without dropping or duplicating pixels.

## Interface
- WIDTH, 30, pixels per row (>=1)
- HEIGHT, 30, rows per frame (>=1)
- DATA_W, 8, pixel width in bits
- ADDR_W, 10, RAM address width; WIDTH*HEIGHT <= 2**ADDR_W
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin one frame; sampled only in IDLE
- abort  input  1  synchronous abandon of the current frame
- mem_rd_en  output  1  RAM read strobe
- mem_addr  output  ADDR_W  RAM read address, row*WIDTH+col
- mem_rd_data  input  DATA_W  RAM data, valid the cycle after mem_rd_en
- out_valid  output  1  out_data, out_eol and out_eof are valid
- out_ready  input  1  downstream accepts the pixel this cycle
- out_data  output  DATA_W  pixel
- out_eol  output  1  pixel is the last one in its row
- out_eof  output  1  pixel is the last one in the frame
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final pixel handshake
- frame_count  output  8  number of completed frames, wraps 255->0

## Operation
- States: IDLE, RUN.
  - IDLE -> RUN when start=1. The read address counter and the row/column counters clear to 0.
  - RUN -> IDLE on the final-pixel handshake (out_valid & out_ready & out_eof). On the following cycle done=1 and frame_count increments.
  - RUN -> IDLE on abort=1. The output buffer and the in-flight read are flushed; done stays 0 and frame_count does not change.
- start has no effect in RUN. abort has no effect in IDLE. If abort and the final handshake occur in the same cycle, the final handshake wins: it completes and done pulses.
- Output buffer: 2-entry FIFO holding {data, eol, eof}.
  - A read is issued (mem_rd_en=1) only in RUN, only while the address counter is below WIDTH*HEIGHT, and only when FIFO occupancy + in-flight reads - (pop this cycle) < 2. A pixel therefore can never arrive to a full FIFO.
  - A returning read is pushed at the edge after mem_rd_en. eol and eof are computed from the address at issue time and carried through the pipeline with the read.
  - A push and a pop in the same cycle leave occupancy unchanged.
- out_valid = FIFO non-empty. out_data, out_eol and out_eof come from the FIFO head and stay stable while out_valid=1 and out_ready=0.
- Counters:
  - The column counter wraps WIDTH-1 -> 0 and increments the row counter.
  - mem_addr advances by 1 per issued read. It holds its value when no read is issued.
- Degenerate sizes: with WIDTH=1 every pixel has eol=1. With WIDTH=HEIGHT=1 the single pixel has eol=eof=1.

## Timing
- Reset values: state IDLE; mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_eol=0, out_eof=0, busy=0, done=0, frame_count=0; FIFO empty.
- Reset asserted mid-frame: all of the above are applied immediately. The frame is lost and not counted.
- Edge E0 samples start=1.
  - Cycle 1: busy=1, mem_rd_en=1, mem_addr=0.
  - Cycle 2: mem_rd_data holds pixel 0 and is pushed at edge E2.
  - Cycle 3: first out_valid=1.
- With out_ready held at 1, throughput is one pixel per cycle. A full frame takes WIDTH*HEIGHT+2 cycles from the first mem_rd_en to the final handshake. done follows one cycle after that handshake.
- Backpressure: out_ready=0 for N cycles stalls reads within 2 cycles. No pixel is lost or repeated.
- busy falls in the same cycle that done rises. A new start is accepted in that same done cycle.

## Test plan
- Default 30x30 with RAM[i] = i mod 256 and out_ready=1 -> 900 pixels 0,1,...,255,0,...; out_eol on indices 29, 59, ..., 899; out_eof only on 899; done one cycle later; frame_count=1.
- out_ready toggling with a random 50% duty -> output sequence identical to the first scenario; mem_rd_en never drives the FIFO beyond 2 entries; output stays stable throughout each stall.
- abort after the 100th handshake -> IDLE next cycle, out_valid=0, no done, frame_count unchanged; a following start replays from pixel 0.
- rst pulse during RUN at pixel 450 -> all outputs at reset values asynchronously; frame_count=0.
- Three back-to-back frames with start asserted in each done cycle -> frame_count 1, 2, 3; no idle gap beyond the 2-cycle RAM restart; wrap of frame_count 255->0 checked with a forced count.
- WIDTH=1, HEIGHT=1 -> a single pixel with eol=eof=1; done; start during busy ignored.

Source files
------------

// File: rtl/pixel_stream_ctrl.sv
// Raster-scan read sequencer: walks a WIDTH x HEIGHT RAM buffer and streams the
// pixels in raster order with end-of-line / end-of-frame markers.
module pixel_stream_ctrl #(
  parameter int WIDTH  = 30,
  parameter int HEIGHT = 30,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_count
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  // One spare address bit so a frame filling the whole RAM can still terminate
  logic [ADDR_W:0]    addr_cnt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               pend, pend_eol, pend_eof;
  logic [DATA_W-1:0]  fifo_data [2];
  logic [1:0]         fifo_eol, fifo_eof;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic               pop, last_hs, flush, issue, at_eol, at_eof;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_eol   = fifo_eol[rd_ptr];
  assign out_eof   = fifo_eof[rd_ptr];
  assign busy      = (state == RUN);
  assign mem_rd_en = issue;
  assign mem_addr  = addr_cnt[ADDR_W-1:0];

  always_comb begin
    pop     = out_valid & out_ready;
    last_hs = (state == RUN) & pop & out_eof;
    flush   = (state == RUN) & abort & ~last_hs;
    at_eol  = (col == COL_W'(WIDTH - 1));
    at_eof  = at_eol && (row == ROW_W'(HEIGHT - 1));
    // Reads in flight count against FIFO space so a returning pixel always fits
    issue   = (state == RUN) && !abort
              && (addr_cnt < (ADDR_W + 1)'(TOTAL))
              && (({1'b0, count} + {2'b0, pend}) < (3'd2 + {2'b0, pop}));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (last_hs)    state_next = IDLE;
        else if (abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      col      <= '0;
      row      <= '0;
    end else if (state == IDLE && start) begin
      addr_cnt <= '0;
      col      <= '0;
      row      <= '0;
    end else if (issue) begin
      addr_cnt <= addr_cnt + 1'b1;
      col      <= at_eol ? '0 : col + 1'b1;
      row      <= at_eol ? row + 1'b1 : row;
    end
  end

  // Line/frame markers ride alongside the read through the RAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_eol <= 1'b0;
      pend_eof <= 1'b0;
    end else begin
      pend     <= issue;
      pend_eol <= issue & at_eol;
      pend_eof <= issue & at_eof;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_eol <= '0;
      fifo_eof <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (pend) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_eol[wr_ptr]  <= pend_eol;
        fifo_eof[wr_ptr]  <= pend_eof;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, pend} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= last_hs;
      if (last_hs) frame_count <= frame_count + 1'b1;
    end
  end

endmodule
